free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter FL_DEPTH, default 64: free-list entries (power of two).
REQ-002 SHALL have parameter FL_INDEX, default 6: log2(FL_DEPTH).
REQ-003 SHALL have parameter TAG_W, default 7: physical register tag width.
REQ-004 SHALL have parameter ARCH_REGS, default 32: architectural registers, identity-mapped at reset.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port popReq_i, input, 1: the rename stage requests tags this cycle.
REQ-008 SHALL have port popCnt_i, input, 3: tags requested, 0..4.
REQ-009 SHALL have ports freeTag0_o..freeTag3_o, output, TAG_W each: tags at head+0..head+3.
REQ-010 SHALL have port stall_o, output, 1: the request cannot be granted.
REQ-011 SHALL have ports pushValid0_i..pushValid3_i, input, 1 each: retire lane k frees a tag.
REQ-012 SHALL have ports pushTag0_i..pushTag3_i, input, TAG_W each: freed tag (old map-table mapping of the retiring instruction).
REQ-013 SHALL have port freeCount_o, output, FL_INDEX+1: entries currently free.
REQ-014 SHALL have port error_o, output, 1: sticky overflow/underflow flag.

Function
REQ-015 SHALL hold storage of FL_DEPTH x TAG_W, with head and tail pointers of FL_INDEX bits and a count of FL_INDEX+1 bits.
REQ-016 SHALL drive freeTagk_o = list[(head+k) mod FL_DEPTH] combinationally, with no cycle of read latency.
REQ-017 SHALL assert stall_o combinationally when popReq_i=1 and popCnt_i > count (pre-update count); stall_o SHALL be 0 when popReq_i=0.
REQ-018 SHALL treat a grant (popReq_i=1 and stall_o=0) as head += popCnt_i and count -= popCnt_i; a stalled request SHALL pop nothing (all-or-nothing).
REQ-019 SHALL compact push lanes: a valid lane k SHALL be written at tail + (number of valid lanes below k); tail += number of valid lanes.
REQ-020 SHALL update count on a simultaneous push and pop as count + pushes - pops in the same cycle.
REQ-021 SHALL make tags pushed in cycle N poppable no earlier than cycle N+1 (no push-to-pop bypass).
REQ-022 SHALL wrap head and tail modulo FL_DEPTH.
REQ-023 SHALL drive freeCount_o = count (registered).
REQ-024 SHALL, on overflow (count + pushes - pops > FL_DEPTH), drop the excess pushes and leave count saturated at FL_DEPTH.
REQ-025 SHALL assert popCnt_i > 4 as a stall.

Reset
REQ-026 SHALL, while reset=1 at a clock edge, set head=0, tail=0, count=FL_DEPTH, list[j]=ARCH_REGS+j for every j, and error_o=0.
REQ-027 SHALL drive stall_o=0 at reset (popReq_i ignored); reset asserted mid-operation SHALL discard all pushes and pops of that cycle.

Configuration
REQ-028 SHALL, with FREE_LIST_ERR_EN defined, set error_o to 1 on overflow (REQ-024) or on a pop granted with count<popCnt_i, holding it until reset, and SHALL include simulation assertions for both conditions.
REQ-029 SHALL, without FREE_LIST_ERR_EN, tie error_o to 0, include no checker logic, and keep overflow handling per REQ-024.

Structure
REQ-030 SHALL place FL_DEPTH, FL_INDEX, TAG_W, ARCH_REGS and the pipeline width (4) in the shared core configuration package.
REQ-031 SHALL implement the push-lane prefix-offset computation in a sub-module free_list_push_compact (4 valid bits in, 4 offsets plus total out).

Verification
REQ-032 SHALL cover: reset with defaults -> freeCount_o=64; freeTag0_o..3_o=32,33,34,35; stall_o=0.
REQ-033 SHALL cover: pop 4 per cycle for 16 cycles -> freeCount_o=0; a 17th request with popCnt_i=1 -> stall_o=1 and head unchanged.
REQ-034 SHALL cover: count=2, popCnt_i=3 -> stall_o=1; the same cycle with pushValid0_i=1 -> next cycle count=3, and the pushed tag is not visible in that cycle's freeTag outputs.
REQ-035 SHALL cover: pushValid=1010 with tags 40 and 41 at tail=62 -> list[62]=40, list[63]=41, tail=0.
REQ-036 SHALL cover: count=10, pop 3 and push 4 in the same cycle -> count=11.
REQ-037 SHALL cover: at count=64, push 1 -> count stays 64; error_o=1 only when FREE_LIST_ERR_EN is defined, and cleared only by reset.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared core configuration for the rename free list: list geometry, tag width,
// architectural register count and the rename/retire pipeline width.
package free_list_pkg;

  localparam int FL_DEPTH  = 64;
  localparam int FL_INDEX  = 6;
  localparam int TAG_W     = 7;
  localparam int ARCH_REGS = 32;
  localparam int PIPE_W    = 4;

endpackage

// File: rtl/free_list_push_compact.sv
// Prefix-offset computation for the retire push lanes: each valid lane gets the
// number of valid lanes below it, plus the total count of valid lanes.
module free_list_push_compact
  import free_list_pkg::*;
(
  input  logic [PIPE_W-1:0]      valid,
  output logic [PIPE_W-1:0][1:0] offset,
  output logic [2:0]             total
);

  logic [2:0] acc_s;

  // running count of valid lanes below each lane
  always_comb begin
    acc_s  = 3'd0;
    offset = '0;
    for (int k = 0; k < PIPE_W; k++) begin
      offset[k] = acc_s[1:0];
      acc_s     = acc_s + {2'b00, valid[k]};
    end
    total = acc_s;
  end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical register tags, 4-wide pop and compacted 4-wide push.
// Optional sticky overflow/underflow flag and checker enabled by FREE_LIST_ERR_EN.
module free_list
  import free_list_pkg::*;
#(
  parameter int FL_DEPTH  = free_list_pkg::FL_DEPTH,
  parameter int FL_INDEX  = free_list_pkg::FL_INDEX,
  parameter int TAG_W     = free_list_pkg::TAG_W,
  parameter int ARCH_REGS = free_list_pkg::ARCH_REGS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               popReq_i,
  input  logic [2:0]         popCnt_i,
  output logic [TAG_W-1:0]   freeTag0_o,
  output logic [TAG_W-1:0]   freeTag1_o,
  output logic [TAG_W-1:0]   freeTag2_o,
  output logic [TAG_W-1:0]   freeTag3_o,
  output logic               stall_o,
  input  logic               pushValid0_i,
  input  logic               pushValid1_i,
  input  logic               pushValid2_i,
  input  logic               pushValid3_i,
  input  logic [TAG_W-1:0]   pushTag0_i,
  input  logic [TAG_W-1:0]   pushTag1_i,
  input  logic [TAG_W-1:0]   pushTag2_i,
  input  logic [TAG_W-1:0]   pushTag3_i,
  output logic [FL_INDEX:0]  freeCount_o,
  output logic               error_o
);

  localparam int CNT_W = FL_INDEX + 1;

  logic [TAG_W-1:0]      list_r [FL_DEPTH];
  logic [FL_INDEX-1:0]   head_r;
  logic [FL_INDEX-1:0]   tail_r;
  logic [CNT_W-1:0]      count_r;
  logic                  error_r;

  logic [PIPE_W-1:0]      push_valid_s;
  logic [TAG_W-1:0]       push_tag_s [PIPE_W];
  logic [PIPE_W-1:0][1:0] push_off_s;
  logic [2:0]             push_total_s;
  logic [2:0]             push_acc_s;
  logic [2:0]             pop_num_s;
  logic                   stall_s;
  logic                   grant_s;
  logic [CNT_W:0]         room_s;

  assign push_valid_s  = {pushValid3_i, pushValid2_i, pushValid1_i, pushValid0_i};
  assign push_tag_s[0] = pushTag0_i;
  assign push_tag_s[1] = pushTag1_i;
  assign push_tag_s[2] = pushTag2_i;
  assign push_tag_s[3] = pushTag3_i;

  free_list_push_compact u_compact (
    .valid  (push_valid_s),
    .offset (push_off_s),
    .total  (push_total_s)
  );

  assign freeTag0_o  = list_r[head_r];
  assign freeTag1_o  = list_r[head_r + FL_INDEX'(1)];
  assign freeTag2_o  = list_r[head_r + FL_INDEX'(2)];
  assign freeTag3_o  = list_r[head_r + FL_INDEX'(3)];
  assign stall_o     = stall_s;
  assign freeCount_o = count_r;
  assign error_o     = error_r;

  // pop grant decision and number of pushes that still fit after this cycle's pops
  always_comb begin
    stall_s   = 1'b0;
    grant_s   = 1'b0;
    pop_num_s = 3'd0;
    if (reset) begin
      stall_s = 1'b0;
    end else if (popReq_i) begin
      if ((popCnt_i > 3'd4) || (CNT_W'(popCnt_i) > count_r)) begin
        stall_s = 1'b1;
      end else begin
        grant_s   = 1'b1;
        pop_num_s = popCnt_i;
      end
    end else begin
      stall_s = 1'b0;
    end
    room_s = (CNT_W+1)'(FL_DEPTH) - {1'b0, count_r} + (CNT_W+1)'(pop_num_s);
    // excess pushes beyond the free room are dropped from the highest lanes
    if ((CNT_W+1)'(push_total_s) > room_s) begin
      push_acc_s = room_s[2:0];
    end else begin
      push_acc_s = push_total_s;
    end
  end

  // storage, pointers and count update
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= CNT_W'(FL_DEPTH);
      for (int j = 0; j < FL_DEPTH; j++) begin
        list_r[j] <= TAG_W'(ARCH_REGS + j);
      end
    end else begin
      for (int k = 0; k < PIPE_W; k++) begin
        if (push_valid_s[k] && ({1'b0, push_off_s[k]} < push_acc_s)) begin
          list_r[tail_r + FL_INDEX'(push_off_s[k])] <= push_tag_s[k];
        end
      end
      head_r  <= head_r + FL_INDEX'(pop_num_s);
      tail_r  <= tail_r + FL_INDEX'(push_acc_s);
      count_r <= count_r - CNT_W'(pop_num_s) + CNT_W'(push_acc_s);
    end
  end

`ifdef FREE_LIST_ERR_EN
  logic overflow_s;
  logic bad_pop_s;

  assign overflow_s = !reset && ((CNT_W+1)'(push_total_s) > room_s);
  assign bad_pop_s  = !reset && grant_s && (CNT_W'(pop_num_s) > count_r);

  // sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      error_r <= 1'b0;
    end else begin
      error_r <= error_r | overflow_s | bad_pop_s;
    end
  end

  free_list_chk u_chk (
    .clk      (clk),
    .reset    (reset),
    .overflow (overflow_s),
    .bad_pop  (bad_pop_s)
  );
`else
  assign error_r = 1'b0;
`endif

endmodule

`ifdef FREE_LIST_ERR_EN
// Simulation checker for the free list error conditions.
module free_list_chk (
  input logic clk,
  input logic reset,
  input logic overflow,
  input logic bad_pop
);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !overflow)
    else $error("free_list: push overflow, excess tags dropped");

  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !bad_pop)
    else $error("free_list: pop granted beyond free count");

endmodule
`endif

// File: tb/tb_free_list.sv
// Randomized and directed bench for free_list against a queue-based reference model.
module tb_free_list;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       popReq_i = 1'b0;
  logic [2:0] popCnt_i = 3'd0;
  logic [6:0] freeTag0_o, freeTag1_o, freeTag2_o, freeTag3_o;
  logic       stall_o;
  logic       pushValid0_i = 1'b0, pushValid1_i = 1'b0, pushValid2_i = 1'b0, pushValid3_i = 1'b0;
  logic [6:0] pushTag0_i = 7'd0, pushTag1_i = 7'd0, pushTag2_i = 7'd0, pushTag3_i = 7'd0;
  logic [6:0] freeCount_o;
  logic       error_o;

  int q[$];
  bit err_m;
  int n_tests = 0;
  int n_fail  = 0;

  free_list dut (
    .clk          (clk),
    .reset        (reset),
    .popReq_i     (popReq_i),
    .popCnt_i     (popCnt_i),
    .freeTag0_o   (freeTag0_o),
    .freeTag1_o   (freeTag1_o),
    .freeTag2_o   (freeTag2_o),
    .freeTag3_o   (freeTag3_o),
    .stall_o      (stall_o),
    .pushValid0_i (pushValid0_i),
    .pushValid1_i (pushValid1_i),
    .pushValid2_i (pushValid2_i),
    .pushValid3_i (pushValid3_i),
    .pushTag0_i   (pushTag0_i),
    .pushTag1_i   (pushTag1_i),
    .pushTag2_i   (pushTag2_i),
    .pushTag3_i   (pushTag3_i),
    .freeCount_o  (freeCount_o),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] tag_out(input int k);
    case (k)
      0:       return freeTag0_o;
      1:       return freeTag1_o;
      2:       return freeTag2_o;
      default: return freeTag3_o;
    endcase
  endfunction

  function automatic void model_reset();
    q.delete();
    for (int j = 0; j < 64; j++) q.push_back(32 + j);
    err_m = 1'b0;
  endfunction

  // One cycle: drive inputs, compare outputs against the model, then advance the model.
  task automatic step(input bit rst, input bit req, input int cnt, input bit [3:0] pv,
                      input int t0, input int t1, input int t2, input int t3);
    int  t[4];
    bit  grant;
    bit  ovf;
    t = '{t0, t1, t2, t3};
    @(negedge clk);
    reset        = rst;
    popReq_i     = req;
    popCnt_i     = 3'(cnt);
    pushValid0_i = pv[0];
    pushValid1_i = pv[1];
    pushValid2_i = pv[2];
    pushValid3_i = pv[3];
    pushTag0_i   = 7'(t0);
    pushTag1_i   = 7'(t1);
    pushTag2_i   = 7'(t2);
    pushTag3_i   = 7'(t3);
    #1;
    grant = !rst && req && (cnt <= 4) && (cnt <= q.size());
    check("stall", {31'd0, stall_o}, {31'd0, (!rst && req && !grant)});
    check("count", {25'd0, freeCount_o}, q.size());
    check("error", {31'd0, error_o}, {31'd0, err_m});
    for (int k = 0; k < 4; k++) begin
      if (k < q.size()) check($sformatf("tag%0d", k), {25'd0, tag_out(k)}, q[k]);
    end
    if (rst) begin
      model_reset();
    end else begin
      if (grant) repeat (cnt) void'(q.pop_front());
      ovf = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (pv[k]) begin
          if (q.size() < 64) q.push_back(t[k]);
          else ovf = 1'b1;
        end
      end
`ifdef FREE_LIST_ERR_EN
      if (ovf) err_m = 1'b1;
`endif
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 4'b0000, 0, 0, 0, 0);
  endtask

  task automatic pops(input int n, input int cnt);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, cnt, 4'b0000, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset        = 1'b1;
    popReq_i     = 1'b0;
    pushValid0_i = 1'b0;
    pushValid1_i = 1'b0;
    pushValid2_i = 1'b0;
    pushValid3_i = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  initial begin
    // reset values
    apply_reset();
    idle();

    // drain 64 tags, then a stalled request
    pops(16, 4);
    step(1'b0, 1'b1, 1, 4'b0000, 0, 0, 0, 0);
    idle();

    // count=2, request 3 stalls while a push lands for the next cycle
    apply_reset();
    pops(15, 4);
    pops(1, 2);
    step(1'b0, 1'b1, 3, 4'b0001, 100, 0, 0, 0);
    idle();

    // compacted push 1010 at tail=62 wraps the tail
    apply_reset();
    pops(16, 4);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 0, 4'b1111, 4*i, 4*i+1, 4*i+2, 4*i+3);
    step(1'b0, 1'b0, 0, 4'b0011, 60, 61, 0, 0);
    step(1'b0, 1'b0, 0, 4'b1010, 0, 40, 0, 41);
    pops(15, 4);
    pops(1, 2);
    step(1'b0, 1'b0, 0, 4'b0001, 77, 0, 0, 0);
    pops(1, 2);
    idle();

    // count=10, pop 3 and push 4 together
    apply_reset();
    pops(13, 4);
    pops(1, 2);
    step(1'b0, 1'b1, 3, 4'b1111, 10, 11, 12, 13);
    idle();

    // overflow at full list, error stays set until reset
    apply_reset();
    step(1'b0, 1'b0, 0, 4'b0001, 5, 0, 0, 0);
    idle();
    step(1'b0, 1'b1, 4, 4'b0001, 6, 0, 0, 0);
    idle();
    apply_reset();
    idle();

    // randomized traffic with occasional mid-operation reset
    for (int i = 0; i < 500; i++) begin
      bit rst;
      bit req;
      int cnt;
      bit [3:0] pv;
      rst = ($urandom_range(0, 59) == 0);
      req = ($urandom_range(0, 2) != 0);
      cnt = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      pv  = 4'($urandom_range(0, 15));
      step(rst, req, cnt, pv, $urandom_range(0, 127), $urandom_range(0, 127),
           $urandom_range(0, 127), $urandom_range(0, 127));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
